uart_transmitter_controller: RTL and testbench

Return-path sequencer of the system controller. Captures register-file read data and ALU results, serializes them into byte-wide messages, and writes them into the TX-side synchronizing FIFO feeding the UART transmitter. It is the counterpart of the receive-side command decoder and shares its clock domain (`clk`, the reference clock).

---
 rtl/system_controller_pkg.sv | 24 ++
 rtl/uart_transmitter_controller_if.sv | 25 ++
 rtl/tx_holding_slot.sv | 34 +++
 rtl/uart_transmitter_controller.sv | 129 ++++++++++++
 tb/tb_uart_transmitter_controller.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/system_controller_pkg.sv
// Shared system-controller definitions: TX FSM state encoding, default byte
// width and per-message byte counts. Optional feature macro:
// UART_TX_CTRL_CHECKSUM_EN (appends one XOR checksum byte to every message).
package system_controller_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;

`ifdef UART_TX_CTRL_CHECKSUM_EN
   localparam int unsigned RD_MSG_BYTES  = 2;
   localparam int unsigned ALU_MSG_BYTES = 3;
`else
   localparam int unsigned RD_MSG_BYTES  = 1;
   localparam int unsigned ALU_MSG_BYTES = 2;
`endif

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_SEND_RD     = 3'd1,
      ST_SEND_ALU_LO = 3'd2,
      ST_SEND_ALU_HI = 3'd3,
      ST_SEND_CSUM   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_transmitter_controller_if.sv
// Capture-side and TX-FIFO-side signals of the UART transmitter controller.
interface uart_transmitter_controller_if #(
   parameter int unsigned DATA_WIDTH = system_controller_pkg::DEFAULT_DATA_WIDTH
);
   logic                    enable;
   logic [DATA_WIDTH-1:0]   read_data;
   logic                    read_data_valid;
   logic [2*DATA_WIDTH-1:0] alu_result;
   logic                    alu_result_valid;
   logic                    fifo_full;
   logic [DATA_WIDTH-1:0]   fifo_write_data;
   logic                    fifo_write_en;
   logic                    busy;
   logic                    overflow;

   modport master (
      output enable, read_data, read_data_valid, alu_result, alu_result_valid, fifo_full,
      input  fifo_write_data, fifo_write_en, busy, overflow
   );

   modport slave (
      input  enable, read_data, read_data_valid, alu_result, alu_result_valid, fifo_full,
      output fifo_write_data, fifo_write_en, busy, overflow
   );
endinterface

// File: rtl/tx_holding_slot.sv
// One holding slot: data register, pending flag and sticky overflow flag.
module tx_holding_slot #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             capture,
   input  logic             clear_pending,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             pending,
   output logic             overflow
);

   // A slot freed on this edge may be refilled on the same edge without overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout     <= '0;
         pending  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (capture && (!pending || clear_pending)) begin
            dout    <= din;
            pending <= 1'b1;
         end else if (clear_pending) begin
            pending <= 1'b0;
         end
         if (capture && pending && !clear_pending) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_transmitter_controller.sv
// Return-path sequencer: captures read data / ALU results and serializes them
// byte-wise into the TX FIFO. Optional macro UART_TX_CTRL_CHECKSUM_EN adds an
// XOR checksum byte after every message.
module uart_transmitter_controller
   import system_controller_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = DEFAULT_DATA_WIDTH,
   parameter int unsigned ALU_RESULT_WIDTH = 2*DATA_WIDTH
) (
   input logic                          clk,
   input logic                          reset_n,
   uart_transmitter_controller_if.slave bus
);

   tx_state_e                   state_q, state_d;
   logic                        alu_msg_q, alu_msg_d;
   logic [DATA_WIDTH-1:0]       rd_data;
   logic [ALU_RESULT_WIDTH-1:0] alu_data;
   logic                        rd_pending, alu_pending;
   logic                        rd_ovf, alu_ovf;
   logic                        rd_clear, alu_clear;
   logic                        wr_en;
   logic [DATA_WIDTH-1:0]       wr_data;
   logic [DATA_WIDTH-1:0]       alu_lo, alu_hi;

   assign alu_lo = alu_data[DATA_WIDTH-1:0];
   assign alu_hi = alu_data[ALU_RESULT_WIDTH-1:DATA_WIDTH];

   tx_holding_slot #(.WIDTH(DATA_WIDTH)) u_rd_slot (
      .clk           (clk),
      .reset_n       (reset_n),
      .capture       (bus.enable && bus.read_data_valid),
      .clear_pending (rd_clear),
      .din           (bus.read_data),
      .dout          (rd_data),
      .pending       (rd_pending),
      .overflow      (rd_ovf)
   );

   tx_holding_slot #(.WIDTH(ALU_RESULT_WIDTH)) u_alu_slot (
      .clk           (clk),
      .reset_n       (reset_n),
      .capture       (bus.enable && bus.alu_result_valid),
      .clear_pending (alu_clear),
      .din           (bus.alu_result),
      .dout          (alu_data),
      .pending       (alu_pending),
      .overflow      (alu_ovf)
   );

   // State register plus which source the current message belongs to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         alu_msg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_msg_q <= alu_msg_d;
      end
   end

   // Next state, FIFO write strobe/data mux and slot release on last byte.
   always_comb begin
      state_d   = state_q;
      alu_msg_d = alu_msg_q;
      wr_en     = 1'b0;
      wr_data   = '0;
      rd_clear  = 1'b0;
      alu_clear = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rd_pending) begin
               state_d   = ST_SEND_RD;
               alu_msg_d = 1'b0;
            end else if (alu_pending) begin
               state_d   = ST_SEND_ALU_LO;
               alu_msg_d = 1'b1;
            end
         end
         ST_SEND_RD: begin
            wr_data = rd_data;
            wr_en   = !bus.fifo_full;
            if (wr_en) begin
`ifdef UART_TX_CTRL_CHECKSUM_EN
               state_d = ST_SEND_CSUM;
`else
               state_d  = ST_IDLE;
               rd_clear = 1'b1;
`endif
            end
         end
         ST_SEND_ALU_LO: begin
            wr_data = alu_lo;
            wr_en   = !bus.fifo_full;
            if (wr_en) begin
               state_d = ST_SEND_ALU_HI;
            end
         end
         ST_SEND_ALU_HI: begin
            wr_data = alu_hi;
            wr_en   = !bus.fifo_full;
            if (wr_en) begin
`ifdef UART_TX_CTRL_CHECKSUM_EN
               state_d = ST_SEND_CSUM;
`else
               state_d   = ST_IDLE;
               alu_clear = 1'b1;
`endif
            end
         end
         ST_SEND_CSUM: begin
            wr_data = alu_msg_q ? (alu_lo ^ alu_hi) : rd_data;
            wr_en   = !bus.fifo_full;
            if (wr_en) begin
               state_d   = ST_IDLE;
               rd_clear  = !alu_msg_q;
               alu_clear = alu_msg_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.fifo_write_en   = wr_en;
   assign bus.fifo_write_data = wr_data;
   assign bus.busy            = rd_pending || alu_pending || (state_q != ST_IDLE);
   assign bus.overflow        = rd_ovf || alu_ovf;

endmodule

// File: tb/tb_uart_transmitter_controller.sv
// Self-checking bench for uart_transmitter_controller: directed scenarios plus
// randomized messages compared against a byte-queue message model.
module tb_uart_transmitter_controller;
   import system_controller_pkg::*;

   localparam int unsigned DW = DEFAULT_DATA_WIDTH;

   logic ref_clk_tb = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [DW-1:0] got_q[$];
   logic [DW-1:0] exp_q[$];

   uart_transmitter_controller_if #(.DATA_WIDTH(DW)) bus ();

   uart_transmitter_controller dut (
      .clk     (ref_clk_tb),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 ref_clk_tb = ~ref_clk_tb;

   // Record every byte the FIFO will accept on the following rising edge.
   always @(negedge ref_clk_tb) begin
      if (reset_n && bus.fifo_write_en) got_q.push_back(bus.fifo_write_data);
   end

   task automatic step();
      @(posedge ref_clk_tb);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Model: a read message is the byte (plus XOR checksum when enabled).
   task automatic add_rd(input logic [DW-1:0] b);
      exp_q.push_back(b);
      if (RD_MSG_BYTES > 1) exp_q.push_back(b);
   endtask

   // Model: an ALU message is low byte, high byte (plus XOR checksum when enabled).
   task automatic add_alu(input logic [2*DW-1:0] r);
      logic [DW-1:0] lo, hi;
      lo = r[DW-1:0];
      hi = r[2*DW-1:DW];
      exp_q.push_back(lo);
      exp_q.push_back(hi);
      if (ALU_MSG_BYTES > 2) exp_q.push_back(lo ^ hi);
   endtask

   task automatic wait_idle(input string tag, input bit rnd);
      for (int i = 0; i < 300; i++) begin
         if (!bus.busy) break;
         if (rnd) bus.fifo_full = ($urandom_range(0, 2) == 0);
         step();
      end
      bus.fifo_full = 1'b0;
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic check_q(input string tag);
      chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      step();
   endtask

   initial begin
      logic [1:0]    kind;
      logic          en;
      logic [DW-1:0] rd;
      logic [2*DW-1:0] alu;

      reset_n              = 1'b0;
      bus.enable           = 1'b0;
      bus.read_data        = '0;
      bus.read_data_valid  = 1'b0;
      bus.alu_result       = '0;
      bus.alu_result_valid = 1'b0;
      bus.fifo_full        = 1'b0;
      repeat (3) step();

      // Reset values
      chk("rst_wr_en",   32'(bus.fifo_write_en),   32'd0);
      chk("rst_wr_data", 32'(bus.fifo_write_data), 32'd0);
      chk("rst_busy",    32'(bus.busy),            32'd0);
      chk("rst_ovf",     32'(bus.overflow),        32'd0);
      reset_n = 1'b1;
      step();

      // Read message 0xCF: strobe appears one cycle after the valid edge
      bus.enable          = 1'b1;
      bus.read_data       = 8'hCF;
      bus.read_data_valid = 1'b1;
      step();
      bus.read_data_valid = 1'b0;
      chk("rd_n0_en",   32'(bus.fifo_write_en), 32'd0);
      chk("rd_n0_busy", 32'(bus.busy),          32'd1);
      step();
      chk("rd_n1_en",   32'(bus.fifo_write_en),   32'd1);
      chk("rd_n1_data", 32'(bus.fifo_write_data), 32'hCF);
      add_rd(8'hCF);
      wait_idle("rd", 1'b0);
      check_q("rd");

      // ALU message 0x1234: low then high byte on consecutive cycles
      bus.alu_result       = 16'h1234;
      bus.alu_result_valid = 1'b1;
      step();
      bus.alu_result_valid = 1'b0;
      step();
      chk("alu_lo_en",   32'(bus.fifo_write_en),   32'd1);
      chk("alu_lo_data", 32'(bus.fifo_write_data), 32'h34);
      step();
      chk("alu_hi_en",   32'(bus.fifo_write_en),   32'd1);
      chk("alu_hi_data", 32'(bus.fifo_write_data), 32'h12);
      add_alu(16'h1234);
      wait_idle("alu", 1'b0);
      check_q("alu");

      // Simultaneous capture, then a read valid while the read slot is still pending
      bus.read_data        = 8'hAA;
      bus.alu_result       = 16'hBEEF;
      bus.read_data_valid  = 1'b1;
      bus.alu_result_valid = 1'b1;
      step();
      bus.alu_result_valid = 1'b0;
      bus.read_data        = 8'h55;
      chk("both_ovf_before", 32'(bus.overflow), 32'd0);
      step();
      bus.read_data_valid = 1'b0;
      chk("both_ovf_after", 32'(bus.overflow), 32'd1);
      add_rd(8'hAA);
      add_alu(16'hBEEF);
      wait_idle("both", 1'b0);
      check_q("both");
      chk("both_ovf_sticky", 32'(bus.overflow), 32'd1);
      do_reset();
      chk("ovf_cleared", 32'(bus.overflow), 32'd0);

      // Read valid on the same edge as the last byte of the pending read: captured
      bus.read_data       = 8'h11;
      bus.read_data_valid = 1'b1;
      step();
      bus.read_data_valid = 1'b0;
      repeat (RD_MSG_BYTES) step();
      bus.read_data       = 8'h22;
      bus.read_data_valid = 1'b1;
      step();
      bus.read_data_valid = 1'b0;
      add_rd(8'h11);
      add_rd(8'h22);
      wait_idle("edge", 1'b0);
      check_q("edge");
      chk("edge_ovf", 32'(bus.overflow), 32'd0);

      // Backpressure while the ALU high byte is due
      bus.alu_result       = 16'h1234;
      bus.alu_result_valid = 1'b1;
      step();
      bus.alu_result_valid = 1'b0;
      step();
      step();
      bus.fifo_full = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_en%0d", i),   32'(bus.fifo_write_en),   32'd0);
         chk($sformatf("bp_data%0d", i), 32'(bus.fifo_write_data), 32'h12);
         step();
      end
      bus.fifo_full = 1'b0;
      #1;
      chk("bp_resume_en",   32'(bus.fifo_write_en),   32'd1);
      chk("bp_resume_data", 32'(bus.fifo_write_data), 32'h12);
      add_alu(16'h1234);
      wait_idle("bp", 1'b0);
      check_q("bp");

      // Reset in the middle of an ALU message
      bus.alu_result       = 16'hABCD;
      bus.alu_result_valid = 1'b1;
      step();
      bus.alu_result_valid = 1'b0;
      step();
      chk("mid_en_before", 32'(bus.fifo_write_en), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_wr_en",   32'(bus.fifo_write_en),   32'd0);
      chk("mid_wr_data", 32'(bus.fifo_write_data), 32'd0);
      chk("mid_busy",    32'(bus.busy),            32'd0);
      chk("mid_ovf",     32'(bus.overflow),        32'd0);
      repeat (3) step();
      reset_n = 1'b1;
      repeat (5) step();
      chk("mid_busy_after", 32'(bus.busy), 32'd0);
      check_q("mid");

      // Valids ignored while disabled
      bus.enable           = 1'b0;
      bus.read_data        = 8'h77;
      bus.alu_result       = 16'h8899;
      bus.read_data_valid  = 1'b1;
      bus.alu_result_valid = 1'b1;
      repeat (2) step();
      bus.read_data_valid  = 1'b0;
      bus.alu_result_valid = 1'b0;
      repeat (4) step();
      chk("dis_busy", 32'(bus.busy),     32'd0);
      chk("dis_ovf",  32'(bus.overflow), 32'd0);
      check_q("dis");

      // Randomized messages with random backpressure and enable toggling
      for (int it = 0; it < 40; it++) begin
         en   = ($urandom_range(0, 3) != 0);
         kind = 2'($urandom_range(1, 3));
         rd   = DW'($urandom);
         alu  = (2*DW)'($urandom);
         bus.enable           = en;
         bus.read_data        = rd;
         bus.alu_result       = alu;
         bus.read_data_valid  = kind[0];
         bus.alu_result_valid = kind[1];
         if (en && kind[0]) add_rd(rd);
         if (en && kind[1]) add_alu(alu);
         step();
         bus.read_data_valid  = 1'b0;
         bus.alu_result_valid = 1'b0;
         bus.enable           = 1'($urandom_range(0, 1));
         wait_idle($sformatf("rnd%0d", it), 1'b1);
         check_q($sformatf("rnd%0d", it));
         chk($sformatf("rnd%0d_ovf", it), 32'(bus.overflow), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
